// File: rtl/trivium_out_fifo.sv
// rtl/trivium_out_fifo.sv - show-ahead byte FIFO between the Trivium cipher core and its consumer
//
// Purpose: buffers ciphertext bytes from the cipher core and presents the
// head byte to a valid/ready consumer. It reports a 2-bit condition code
// back to the core. The overflow condition is sticky until clr or rst.
//
// Parameters:
//   DEPTH      storage depth in bytes (power of two, 4..1024)
//   AW         pointer width, derived from DEPTH
//
// Ports:
//   clk        clock, rising edge
//   rst        asynchronous active-low reset
//   clr        synchronous flush, active-high (wins over push/pop)
//   stream     ciphertext byte from the cipher core
//   wt_sgn     write strobe for stream
//   fifo_cnd   condition code: 11 overflow, 10 full, 00 empty, 01 otherwise
//   out_data   head-of-queue byte (don't-care while out_valid=0)
//   out_valid  out_data holds a valid byte
//   out_ready  consumer accepts out_data
//   level      stored byte count (only with TRIV_OFIFO_LEVEL_EN defined)
//
// Build option: define TRIV_OFIFO_LEVEL_EN to expose the level port.

module trivium_out_fifo #(
  parameter int DEPTH = 256,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic [7:0]    stream,
  input  logic          wt_sgn,
  output logic [1:0]    fifo_cnd,
  output logic [7:0]    out_data,
  output logic          out_valid,
  input  logic          out_ready
`ifdef TRIV_OFIFO_LEVEL_EN
  ,
  output logic [AW:0]   level
`endif
);

  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          ovf;

  logic          full;
  logic          empty;
  logic          pop;
  logic          push;
  logic          drop;
  logic [AW:0]   count_nxt;
  logic          ovf_nxt;
  logic [1:0]    cnd_nxt;

  assign full  = (count == FULL_CNT);
  assign empty = (count == '0);

  // A pop frees the slot at the same edge, so a full FIFO still accepts a
  // push when the consumer is taking the head byte.
  assign pop  = !empty && out_ready;
  assign push = wt_sgn && (!full || pop);
  assign drop = wt_sgn && full && !pop;

  assign out_valid = !empty;
  assign out_data  = mem[rd_ptr];

`ifdef TRIV_OFIFO_LEVEL_EN
  assign level = count;
`endif

  always_comb begin
    count_nxt = count;
    case ({push, pop})
      2'b10:   count_nxt = count + (AW+1)'(1);
      2'b01:   count_nxt = count - (AW+1)'(1);
      default: count_nxt = count;
    endcase
  end

  assign ovf_nxt = ovf | drop;

  // The condition code is computed from next-state values so the registered
  // code matches the count that results from this edge.
  always_comb begin
    cnd_nxt = 2'b01;
    if (ovf_nxt)
      cnd_nxt = 2'b11;
    else if (count_nxt == FULL_CNT)
      cnd_nxt = 2'b10;
    else if (count_nxt == '0)
      cnd_nxt = 2'b00;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      ovf      <= 1'b0;
      fifo_cnd <= 2'b00;
    end else if (clr) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      ovf      <= 1'b0;
      fifo_cnd <= 2'b00;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + AW'(1);
      if (pop)
        rd_ptr <= rd_ptr + AW'(1);
      count    <= count_nxt;
      ovf      <= ovf_nxt;
      fifo_cnd <= cnd_nxt;
    end
  end

  // Storage is never cleared. A stray write while rst is low lands at
  // address 0, which the first real push after release overwrites.
  always_ff @(posedge clk) begin
    if (push && !clr)
      mem[wr_ptr] <= stream;
  end

endmodule

// File: tb/tb_trivium_out_fifo.sv
// tb/tb_trivium_out_fifo.sv - scoreboard testbench for trivium_out_fifo

module tb_trivium_out_fifo;

  localparam int DEPTH = 256;
  localparam int AW    = $clog2(DEPTH);

  logic          clk;
  logic          rst;
  logic          clr;
  logic [7:0]    stream;
  logic          wt_sgn;
  logic [1:0]    fifo_cnd;
  logic [7:0]    out_data;
  logic          out_valid;
  logic          out_ready;
`ifdef TRIV_OFIFO_LEVEL_EN
  logic [AW:0]   level;
`endif

  int checks   = 0;
  int failures = 0;
  logic [7:0] sb [$];

  trivium_out_fifo #(.DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .clr       (clr),
    .stream    (stream),
    .wt_sgn    (wt_sgn),
    .fifo_cnd  (fifo_cnd),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready)
`ifdef TRIV_OFIFO_LEVEL_EN
    ,
    .level     (level)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic chk_level(input string name, input int exp);
`ifdef TRIV_OFIFO_LEVEL_EN
    chk(name, int'(level), exp);
`else
    if (exp < 0) $display("unused %s", name);
`endif
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: each handshake seen between edges is a pop at the next edge.
  always @(negedge clk) begin
    if (rst && out_valid && out_ready) begin
      checks++;
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL pop_unexpected: got 0x%0h expected no valid byte", out_data);
      end else begin
        logic [7:0] exp;
        exp = sb.pop_front();
        if (out_data !== exp) begin
          failures++;
          $display("FAIL pop_data: got 0x%0h expected 0x%0h", out_data, exp);
        end
      end
    end
  end

  initial begin
    rst = 1'b0; clr = 1'b0; stream = 8'h00; wt_sgn = 1'b0; out_ready = 1'b0;
    #12;
    chk("reset_cnd", int'(fifo_cnd), 0);
    chk("reset_valid", int'(out_valid), 0);
    chk_level("reset_level", 0);
    tick();
    rst = 1'b1;
    tick();

    // Single push, consumer stalled
    stream = 8'hA5; wt_sgn = 1'b1; sb.push_back(8'hA5);
    tick();
    wt_sgn = 1'b0;
    chk("one_valid", int'(out_valid), 1);
    chk("one_data", int'(out_data), 'hA5);
    chk("one_cnd", int'(fifo_cnd), 1);
    chk_level("one_level", 1);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("one_drain_cnd", int'(fifo_cnd), 0);

    // Fill to full, then drain in order
    for (int i = 0; i < DEPTH; i++) begin
      stream = 8'(i); wt_sgn = 1'b1; sb.push_back(8'(i));
      tick();
      if (i == DEPTH-2) chk("fill_almost_cnd", int'(fifo_cnd), 1);
    end
    wt_sgn = 1'b0;
    chk("fill_full_cnd", int'(fifo_cnd), 2);
    chk_level("fill_full_level", DEPTH);
    out_ready = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      tick();
      if (i == DEPTH-2) chk("drain_last_cnd", int'(fifo_cnd), 1);
    end
    out_ready = 1'b0;
    chk("drain_empty_cnd", int'(fifo_cnd), 0);
    chk("drain_empty_valid", int'(out_valid), 0);

    // Refill, then push with simultaneous pop while full
    for (int i = 0; i < DEPTH; i++) begin
      stream = 8'(i) ^ 8'h5A; wt_sgn = 1'b1; sb.push_back(8'(i) ^ 8'h5A);
      tick();
    end
    stream = 8'h55; out_ready = 1'b1; sb.push_back(8'h55);
    tick();
    wt_sgn = 1'b0; out_ready = 1'b0;
    chk("full_pushpop_cnd", int'(fifo_cnd), 2);
    chk_level("full_pushpop_level", DEPTH);

    // Overflow: byte dropped, flag sticky through drains
    stream = 8'h77; wt_sgn = 1'b1;
    tick();
    wt_sgn = 1'b0;
    chk("ovf_cnd", int'(fifo_cnd), 3);
    chk_level("ovf_level", DEPTH);
    tick();
    chk("ovf_hold_cnd", int'(fifo_cnd), 3);
    out_ready = 1'b1;
    repeat (3) tick();
    out_ready = 1'b0;
    chk("ovf_sticky_cnd", int'(fifo_cnd), 3);
    chk_level("ovf_drain_level", DEPTH-3);
    clr = 1'b1; stream = 8'hEE; wt_sgn = 1'b1;
    tick();
    clr = 1'b0; wt_sgn = 1'b0;
    sb.delete();
    chk("clr_cnd", int'(fifo_cnd), 0);
    chk("clr_valid", int'(out_valid), 0);
    chk_level("clr_level", 0);
    tick();
    chk("clr_nopush_valid", int'(out_valid), 0);

    // Asynchronous reset mid-operation
    for (int i = 0; i < 10; i++) begin
      stream = 8'h10 + 8'(i); wt_sgn = 1'b1; sb.push_back(8'h10 + 8'(i));
      tick();
    end
    wt_sgn = 1'b0;
    chk("pre_rst_cnd", int'(fifo_cnd), 1);
    #2 rst = 1'b0;
    #1;
    chk("async_rst_cnd", int'(fifo_cnd), 0);
    chk("async_rst_valid", int'(out_valid), 0);
    sb.delete();
    tick();
    rst = 1'b1;
    tick();
    stream = 8'h3C; wt_sgn = 1'b1; sb.push_back(8'h3C);
    tick();
    wt_sgn = 1'b0;
    chk("post_rst_data", int'(out_data), 'h3C);
    chk("post_rst_valid", int'(out_valid), 1);
    chk("post_rst_cnd", int'(fifo_cnd), 1);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("post_rst_drain_cnd", int'(fifo_cnd), 0);

    // out_ready while empty has no effect
    out_ready = 1'b1;
    repeat (3) tick();
    chk("underflow_cnd", int'(fifo_cnd), 0);
    chk("underflow_valid", int'(out_valid), 0);
    chk_level("underflow_level", 0);
    stream = 8'h81; wt_sgn = 1'b1; sb.push_back(8'h81);
    tick();
    wt_sgn = 1'b0;
    chk("empty_push_ready_cnd", int'(fifo_cnd), 1);
    tick();
    chk("empty_push_ready_drain", int'(fifo_cnd), 0);

    // Streaming with pointers wrapping
    for (int i = 0; i < 1000; i++) begin
      stream = 8'(i * 7 + 3); wt_sgn = 1'b1; sb.push_back(8'(i * 7 + 3));
      tick();
      chk("stream_cnd", int'(fifo_cnd), 1);
    end
    wt_sgn = 1'b0;
    tick();
    out_ready = 1'b0;
    chk("stream_end_cnd", int'(fifo_cnd), 0);
    tick();
    chk("sb_empty", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/trivium_out_fifo.md
TRIVIUM_OUT_FIFO -- requirements
Module: trivium_out_fifo

Interface
REQ-001 Parameter: DEPTH, 256, storage depth in bytes; power of two, 4..1024.
REQ-002 Parameter: AW, $clog2(DEPTH), pointer width; derived, not overridden.
REQ-003 Port: clk  input  1  clock, all state updates on rising edge.
REQ-004 Port: rst  input  1  reset, asynchronous, active-low.
REQ-005 Port: clr  input  1  synchronous flush, active-high.
REQ-006 Port: stream  input  8  ciphertext byte from the cipher core.
REQ-007 Port: wt_sgn  input  1  write strobe; stream valid when high.
REQ-008 Port: fifo_cnd  output  2  condition code returned to the cipher core.
REQ-009 Port: out_data  output  8  head-of-queue byte.
REQ-010 Port: out_valid  output  1  out_data holds a valid byte.
REQ-011 Port: out_ready  input  1  consumer accepts out_data.
REQ-012 Port (only with TRIV_OFIFO_LEVEL_EN): level  output  AW+1  stored byte count.

Function
REQ-013 Storage: DEPTH x 8 register array; write pointer, read pointer (AW bits, wrap modulo DEPTH), count (AW+1 bits).
REQ-014 Push: wt_sgn=1 and (count<DEPTH or pop in same cycle) -> stream written at wr_ptr, wr_ptr+1.
REQ-015 Pop: out_valid=1 and out_ready=1 -> rd_ptr+1; handshake completes at that edge.
REQ-016 Show-ahead: out_data = mem[rd_ptr] combinationally; out_valid = (count!=0); byte pushed at edge N visible from edge N.
REQ-017 Simultaneous push and pop: both performed, count unchanged, including at count=DEPTH and count=0 is excluded (no pop when empty).
REQ-018 Push at count=DEPTH without pop: byte dropped, pointers/count unchanged, overflow flag set.
REQ-019 out_ready with out_valid=0: no effect, no underflow.
REQ-020 fifo_cnd encoding, priority high to low: 2'b11 overflow flag set; 2'b10 count=DEPTH; 2'b00 count=0; 2'b01 otherwise.
REQ-021 fifo_cnd registered from next-state values: reflects count after the current edge, no extra cycle lag.
REQ-022 Overflow flag sticky; cleared only by clr or rst.
REQ-023 clr=1: pointers, count, overflow flag zeroed at the edge; concurrent push/pop ignored (clr wins).
REQ-024 Memory contents not cleared by clr or rst; out_data is don't-care while out_valid=0.

Reset
REQ-025 rst low, asynchronously: wr_ptr=0, rd_ptr=0, count=0, overflow=0, fifo_cnd=2'b00, out_valid=0, level=0.
REQ-026 Reset mid-operation discards all stored bytes; first push after release lands at address 0.
REQ-027 Reset release synchronous to clk; no push/pop on the release edge unless rst already high at that edge.

Configuration
REQ-028 Macro TRIV_OFIFO_LEVEL_EN defined: level port present, equal to count, updated each edge, 0..DEPTH.
REQ-029 Macro TRIV_OFIFO_LEVEL_EN undefined: level port absent; all other behaviour identical.

Verification
REQ-030 After rst, push 0xA5 (one wt_sgn pulse), out_ready=0 -> out_valid=1, out_data=0xA5, fifo_cnd=2'b01, level=1.
REQ-031 DEPTH=256: push bytes 0x00..0xFF, out_ready=0 -> fifo_cnd=2'b10 after 256th edge; drain with out_ready=1 -> bytes 0x00..0xFF in order, fifo_cnd=2'b00 after last pop.
REQ-032 Full, push 0x77 with out_ready=0 -> 0x77 dropped, fifo_cnd=2'b11 held; pulse clr -> fifo_cnd=2'b00, out_valid=0.
REQ-033 Full, push 0x55 with simultaneous pop -> no overflow, fifo_cnd stays 2'b10, 0x55 emerges as 256th byte after the pop.
REQ-034 Push 10 bytes, assert rst low between edges -> fifo_cnd=2'b00, out_valid=0 immediately; next push 0x3C -> out_data=0x3C.
REQ-035 Continuous push with out_ready=1 for 1000 cycles, pointers wrapping -> fifo_cnd constant 2'b01 after first push, output sequence equals input sequence.
